// File: rtl/data_mem_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_sequencer_pkg
// Purpose  : Shared definitions for the MEM-stage byte-serial RAM sequencer:
//            FSM state encoding, beat counts and the RW/Size control encodings
//            used by the control unit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package data_mem_sequencer_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    // RAM beats per access type (word assumes a 32-bit pipeline)
    localparam int WORD_BEATS = 4;
    localparam int BYTE_BEATS = 1;

    // Control-unit encodings
    localparam logic RW_STORE  = 1'b1;
    localparam logic RW_LOAD   = 1'b0;
    localparam logic SIZE_BYTE = 1'b1;
    localparam logic SIZE_WORD = 1'b0;

endpackage : data_mem_sequencer_pkg
`default_nettype wire

// File: rtl/data_mem_sequencer_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module   : byte_assembler
// Purpose  : Load-data assembly for the sequencer. Bytes read from the RAM
//            are shifted in MSB first; the completed word is transferred to
//            the held load-result register on the final beat.
// Ports    : Clk, Clr      - clock, async active-high reset
//            clr_i         - zero the shift register (start of a load)
//            shift_i       - shift byte_i into the shift register
//            load_i        - capture the assembled word into rdata_o
//            byte_i        - RAM read byte
//            rdata_o       - held load result
// Revision : 1.0 - initial release
// ============================================================================
module byte_assembler #(
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              clr_i,
    input  logic              shift_i,
    input  logic              load_i,
    input  logic [7:0]        byte_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Only the lower DATA_W-8 bits are kept: the top byte of the assembled
    // word would be shifted out on the next beat, so it never needs storage.
    logic [DATA_W-9:0] rd_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] w_assembled;

    // Value the shift register would hold after this edge, incl. this byte
    assign w_assembled = {rd_q, byte_i};

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            rd_q <= '0;
        end else if (clr_i) begin
            rd_q <= '0;
        end else if (shift_i) begin
            rd_q <= w_assembled[DATA_W-9:0];
        end
    end

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            rdata_q <= '0;
        end else if (load_i) begin
            rdata_q <= w_assembled;
        end
    end

    assign rdata_o = rdata_q;

endmodule : byte_assembler
`default_nettype wire

// File: rtl/data_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_sequencer
// Purpose  : MEM-stage controller for an 8-bit byte-addressed data RAM.
//            Converts word/byte load/store requests into single-byte RAM
//            beats (big-endian, base address = MSB), stalls the pipeline
//            while busy and returns load data with a one-cycle done pulse.
// Ports    : Clk, Clr              - clock, async active-high reset
//            MEM_E/MEM_RW/MEM_Size - request, 1=store / 1=byte
//            mem_addr, mem_wdata   - base byte address, store data
//            stall, done           - pipeline hold, completion pulse
//            mem_rdata             - load result (byte zero-extended)
//            ram_addr/wdata/we     - RAM beat interface
//            ram_rdata             - RAM read byte (combinational)
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_sequencer
    import data_mem_sequencer_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Clr,
    input  logic              MEM_E,
    input  logic              MEM_RW,
    input  logic              MEM_Size,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_we,
    input  logic [7:0]        ram_rdata
);

    localparam int NBEATS = DATA_W / 8;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    seq_state_e        state_q, state_d;
    logic [BEAT_W-1:0] beat_q,  beat_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rw_q,    rw_d;
    logic              size_q,  size_d;

    logic              w_last_beat;
    logic              w_asm_clr;
    logic              w_asm_shift;
    logic              w_asm_load;
    logic [DATA_W-1:0] w_wdata_shifted;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
        end
    end

    // The final beat index depends on the captured access size
    assign w_last_beat = (size_q == SIZE_BYTE)
                       ? (beat_q == BEAT_W'(BYTE_BEATS - 1))
                       : (beat_q == BEAT_W'(NBEATS - 1));

    // ------------------------------------------------------------------
    // Next-state, capture and pipeline handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        size_d  = size_q;
        stall   = 1'b0;
        done    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MEM_E) begin
                    stall   = 1'b1;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    rw_d    = MEM_RW;
                    size_d  = MEM_Size;
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                stall = 1'b1;
                if (w_last_beat) begin
                    state_d = ST_DONE;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
            ST_DONE: begin
                // stall is low here so the pipeline advances exactly once
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // RAM beat interface: derived only from registered state so that the
    // RAM never sees pipeline-input glitches.
    // ------------------------------------------------------------------
    // Bring the current beat's byte to the top: beat 0 is the MSB
    assign w_wdata_shifted = wdata_q << {beat_q, 3'b000};

    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = 8'h00;
        ram_we    = 1'b0;
        if (state_q == ST_XFER) begin
            ram_addr = addr_q + ADDR_W'(beat_q);
            ram_we   = (rw_q == RW_STORE);
            if (size_q == SIZE_BYTE) begin
                ram_wdata = wdata_q[7:0];
            end else begin
                ram_wdata = w_wdata_shifted[DATA_W-1 -: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Load assembly. The shift register is cleared at request capture so a
    // byte load ends up zero-extended after its single shift.
    // ------------------------------------------------------------------
    assign w_asm_clr   = (state_q == ST_IDLE) && MEM_E && (MEM_RW == RW_LOAD);
    assign w_asm_shift = (state_q == ST_XFER) && (rw_q == RW_LOAD);
    assign w_asm_load  = w_asm_shift && w_last_beat;

    byte_assembler #(
        .DATA_W (DATA_W)
    ) u_byte_assembler (
        .Clk     (Clk),
        .Clr     (Clr),
        .clr_i   (w_asm_clr),
        .shift_i (w_asm_shift),
        .load_i  (w_asm_load),
        .byte_i  (ram_rdata),
        .rdata_o (mem_rdata)
    );

endmodule : data_mem_sequencer
`default_nettype wire

// File: tb/tb_data_mem_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_sequencer
// Purpose  : Directed self-checking bench for data_mem_sequencer with a
//            behavioural 256-byte RAM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_sequencer;

    logic        Clk;
    logic        Clr;
    logic        MEM_E;
    logic        MEM_RW;
    logic        MEM_Size;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_rdata;

    logic [7:0]  ram [256];

    int n_vec;
    int n_err;

    data_mem_sequencer #(
        .ADDR_W (8),
        .DATA_W (32)
    ) dut (
        .Clk       (Clk),
        .Clr       (Clr),
        .MEM_E     (MEM_E),
        .MEM_RW    (MEM_RW),
        .MEM_Size  (MEM_Size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .stall     (stall),
        .done      (done),
        .mem_rdata (mem_rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural RAM: combinational read, write on rising edge
    assign ram_rdata = ram[ram_addr];
    always @(posedge Clk) begin
        if (ram_we) ram[ram_addr] <= ram_wdata;
    end

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request (called #1 after a rising edge) and follow it until
    // done, counting stall/ram_we cycles. Request cycle is cycle 1.
    task automatic run_access(input logic rw, input logic sz, input logic [7:0] a,
                              input logic [31:0] wd, output int n_stall,
                              output int done_cyc, output int n_we);
        n_stall  = 0;
        done_cyc = 0;
        n_we     = 0;
        MEM_E     = 1'b1;
        MEM_RW    = rw;
        MEM_Size  = sz;
        mem_addr  = a;
        mem_wdata = wd;
        for (int c = 1; c <= 12 && done_cyc == 0; c++) begin
            @(negedge Clk);
            if (stall)  n_stall++;
            if (ram_we) n_we++;
            if (done)   done_cyc = c;
            @(posedge Clk);
            #1;
            MEM_E = 1'b0;
        end
    endtask

    int ns, dc, nw;
    int d_cyc [2];
    logic [31:0] d_dat [2];
    int nd;
    logic stall7;

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        ram[8'h14] = 8'h01; ram[8'h15] = 8'h02; ram[8'h16] = 8'h03; ram[8'h17] = 8'h04;
        Clr = 1'b1; MEM_E = 1'b0; MEM_RW = 1'b0; MEM_Size = 1'b0;
        mem_addr = 8'h00; mem_wdata = 32'h0;

        // Reset state
        #2;
        check_vec("rst_stall",  {31'd0, stall},  32'd0);
        check_vec("rst_done",   {31'd0, done},   32'd0);
        check_vec("rst_we",     {31'd0, ram_we}, 32'd0);
        check_vec("rst_rdata",  mem_rdata,       32'd0);
        check_vec("rst_addr",   {24'd0, ram_addr},  32'd0);
        check_vec("rst_wdata",  {24'd0, ram_wdata}, 32'd0);
        @(posedge Clk); #1;
        Clr = 1'b0;
        @(posedge Clk); #1;

        // Idle with MEM_E low
        @(negedge Clk);
        check_vec("idle_stall", {31'd0, stall}, 32'd0);
        @(posedge Clk); #1;

        // Word store DEADBEEF @0x10
        run_access(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, ns, dc, nw);
        check_vec("wst_stall", ns, 5);
        check_vec("wst_done",  dc, 6);
        check_vec("wst_we",    nw, 4);
        check_vec("wst_ram",   {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]}, 32'hDEADBEEF);

        // Word load @0x10
        run_access(1'b0, 1'b0, 8'h10, 32'h0, ns, dc, nw);
        check_vec("wld_stall", ns, 5);
        check_vec("wld_done",  dc, 6);
        check_vec("wld_we",    nw, 0);
        check_vec("wld_data",  mem_rdata, 32'hDEADBEEF);

        // Byte load @0x11
        run_access(1'b0, 1'b1, 8'h11, 32'h0, ns, dc, nw);
        check_vec("bld_stall", ns, 2);
        check_vec("bld_done",  dc, 3);
        check_vec("bld_data",  mem_rdata, 32'h000000AD);

        // Byte store 0x12345677 @0x12
        run_access(1'b1, 1'b1, 8'h12, 32'h12345677, ns, dc, nw);
        check_vec("bst_done",  dc, 3);
        check_vec("bst_we",    nw, 1);
        check_vec("bst_ram",   {ram[8'h11], ram[8'h12], ram[8'h13], 8'h00}, 32'hAD77EF00);
        check_vec("bst_hold",  mem_rdata, 32'h000000AD);

        // Wrap-around word store @0xFE, then read it back
        run_access(1'b1, 1'b0, 8'hFE, 32'hA1B2C3D4, ns, dc, nw);
        check_vec("wrap_ram",  {ram[8'hFE], ram[8'hFF], ram[8'h00], ram[8'h01]}, 32'hA1B2C3D4);
        check_vec("wrap_fd",   {24'd0, ram[8'hFD]}, 32'h0);
        run_access(1'b0, 1'b0, 8'hFE, 32'h0, ns, dc, nw);
        check_vec("wrap_load", mem_rdata, 32'hA1B2C3D4);

        // Reset in the third beat of a word store @0x20
        MEM_E = 1'b1; MEM_RW = 1'b1; MEM_Size = 1'b0;
        mem_addr = 8'h20; mem_wdata = 32'h55667788;
        @(posedge Clk); #1; MEM_E = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        check_vec("clr_pre_we", {31'd0, ram_we}, 32'd1);
        Clr = 1'b1;
        #1;
        check_vec("clr_we",    {31'd0, ram_we}, 32'd0);
        check_vec("clr_stall", {31'd0, stall},  32'd0);
        check_vec("clr_rdata", mem_rdata, 32'd0);
        nd = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (done) nd++;
        end
        @(posedge Clk); #1;
        Clr = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge Clk);
            if (done) nd++;
        end
        check_vec("clr_nodone", nd, 0);
        check_vec("clr_ram", {ram[8'h20], ram[8'h21], ram[8'h22], ram[8'h23]}, 32'h55660000);
        @(posedge Clk); #1;

        // Back-to-back word loads @0x10 then @0x14 with MEM_E held high
        nd = 0; stall7 = 1'b0;
        d_cyc[0] = 0; d_cyc[1] = 0; d_dat[0] = '0; d_dat[1] = '0;
        MEM_E = 1'b1; MEM_RW = 1'b0; MEM_Size = 1'b0; mem_addr = 8'h10;
        for (int c = 1; c <= 20 && nd < 2; c++) begin
            logic seen;
            @(negedge Clk);
            seen = done;
            if (done) begin
                d_cyc[nd] = c;
                d_dat[nd] = mem_rdata;
                nd++;
            end
            if (c == 7) stall7 = stall;
            @(posedge Clk); #1;
            if (seen && nd == 1) mem_addr = 8'h14;
            if (nd >= 1 && !seen) MEM_E = 1'b0;
        end
        MEM_E = 1'b0;
        check_vec("b2b_count",  nd, 2);
        check_vec("b2b_done1",  d_cyc[0], 6);
        check_vec("b2b_done2",  d_cyc[1], 12);
        check_vec("b2b_stall7", {31'd0, stall7}, 32'd1);
        check_vec("b2b_data1",  d_dat[0], 32'hDEAD77EF);
        check_vec("b2b_data2",  d_dat[1], 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_data_mem_sequencer
`default_nettype wire
